// File: rtl/stark_pkg.sv
// stark_pkg: shared types for branch-miss recovery.
// Holds address/index widths and the recovery-state encoding.
package stark_pkg;
  localparam int PC_W  = 32;
  localparam int ROB_W = 6;
  localparam int CP_W  = 4;
  typedef logic [PC_W-1:0]  pc_address_t;
  typedef logic [ROB_W-1:0] rob_ndx_t;
  typedef logic [CP_W-1:0]  checkpt_ndx_t;
  typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_RESTORE, ST_REDIRECT} recover_state_t;
endpackage

// File: rtl/stark_rob_age_cmp.sv
// stark_rob_age_cmp: combinational ROB age comparator.
// Ports: head (ROB head), a/b (indices), a_older (age(a) < age(b)).
// Age is the distance from head, wrapping modulo the ROB depth.
module stark_rob_age_cmp
  import stark_pkg::*;
#(
  parameter int ROB_ENTRIES = 64
) (
  input  rob_ndx_t head,
  input  rob_ndx_t a,
  input  rob_ndx_t b,
  output logic     a_older
);
  localparam rob_ndx_t MASK = rob_ndx_t'(ROB_ENTRIES - 1);
  rob_ndx_t age_a, age_b;
  always_comb begin
    age_a   = (a - head) & MASK;
    age_b   = (b - head) & MASK;
    a_older = age_a < age_b;
  end
endmodule

// File: rtl/stark_branchmiss_recover.sv
// stark_branchmiss_recover: branch-miss recovery sequencer.
// Ports: miss_* (miss pulse + payload), rob_head (age reference),
// flush/flush_rob, restore_req/restore_cp/restore_ack,
// redirect_v/redirect_pc/redirect_rdy, busy (dispatch stall),
// miss_count (saturating accepted-miss count). rst is async active-low.
module stark_branchmiss_recover
  import stark_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int ROB_ENTRIES  = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         miss_flag,
  input  pc_address_t  miss_pc,
  input  rob_ndx_t     miss_rob,
  input  checkpt_ndx_t miss_cp,
  input  rob_ndx_t     rob_head,
  output logic         flush,
  output rob_ndx_t     flush_rob,
  output logic         restore_req,
  output checkpt_ndx_t restore_cp,
  input  logic         restore_ack,
  output logic         redirect_v,
  output pc_address_t  redirect_pc,
  input  logic         redirect_rdy,
  output logic         busy,
  output logic [15:0]  miss_count
);
  recover_state_t state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  rob_ndx_t       flush_rob_q, flush_rob_d;
  checkpt_ndx_t   restore_cp_q, restore_cp_d;
  pc_address_t    redirect_pc_q, redirect_pc_d;
  logic [15:0]    miss_count_q, miss_count_d;
  logic           flush_q, flush_d, restore_req_q, restore_req_d;
  logic           redirect_v_q, redirect_v_d, busy_q, busy_d;
  logic           miss_older, accept;

  stark_rob_age_cmp #(.ROB_ENTRIES(ROB_ENTRIES)) u_age (
    .head    (rob_head),
    .a       (miss_rob),
    .b       (flush_rob_q),
    .a_older (miss_older)
  );

  // An accepted miss (from idle, or an older one preempting) outranks any ack/rdy this cycle.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    flush_rob_d   = flush_rob_q;
    restore_cp_d  = restore_cp_q;
    redirect_pc_d = redirect_pc_q;
    accept        = miss_flag && (state_q == ST_IDLE || miss_older);
    if (accept) begin
      state_d       = ST_FLUSH;
      cnt_d         = 4'(FLUSH_CYCLES - 1);
      flush_rob_d   = miss_rob;
      restore_cp_d  = miss_cp;
      redirect_pc_d = miss_pc;
    end else if (state_q == ST_FLUSH) begin
      state_d = (cnt_q == 4'd0) ? ST_RESTORE : ST_FLUSH;
      cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
    end else if (state_q == ST_RESTORE && restore_ack) begin
      state_d = ST_REDIRECT;
    end else if (state_q == ST_REDIRECT && redirect_rdy) begin
      state_d = ST_IDLE;
    end
    miss_count_d  = (accept && miss_count_q != 16'hFFFF) ? miss_count_q + 16'd1 : miss_count_q;
    flush_d       = state_d == ST_FLUSH;
    restore_req_d = state_d == ST_RESTORE;
    redirect_v_d  = state_d == ST_REDIRECT;
    busy_d        = state_d != ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      flush_rob_q   <= '0;
      restore_cp_q  <= '0;
      redirect_pc_q <= '0;
      miss_count_q  <= '0;
      flush_q       <= 1'b0;
      restore_req_q <= 1'b0;
      redirect_v_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      flush_rob_q   <= flush_rob_d;
      restore_cp_q  <= restore_cp_d;
      redirect_pc_q <= redirect_pc_d;
      miss_count_q  <= miss_count_d;
      flush_q       <= flush_d;
      restore_req_q <= restore_req_d;
      redirect_v_q  <= redirect_v_d;
      busy_q        <= busy_d;
    end
  end

  assign flush       = flush_q;
  assign flush_rob   = flush_rob_q;
  assign restore_req = restore_req_q;
  assign restore_cp  = restore_cp_q;
  assign redirect_v  = redirect_v_q;
  assign redirect_pc = redirect_pc_q;
  assign busy        = busy_q;
  assign miss_count  = miss_count_q;
endmodule

// File: doc/stark_branchmiss_recover.md
STARK_BRANCHMISS_RECOVER -- requirements
Module: Stark_branchmiss_recover

Interface
REQ-001 Parameters SHALL be: FLUSH_CYCLES, default 2, number of cycles flush is held (legal range 1..15); ROB_ENTRIES, default 64, ROB depth (power of two).
REQ-002 Ports SHALL be, in order:
- clk  in  1  core clock; single clock domain.
- rst  in  1  reset, asynchronous, active-low.
- miss_flag  in  1  one-cycle branch-miss pulse from the branch-miss flag generator.
- miss_pc  in  pc_address_t  correct target address, valid with miss_flag.
- miss_rob  in  rob_ndx_t  ROB index of the missing branch, valid with miss_flag.
- miss_cp  in  checkpt_ndx_t  rename checkpoint of the branch, valid with miss_flag.
- rob_head  in  rob_ndx_t  current ROB head, used for age comparison.
- flush  out  1  pipeline flush, younger than flush_rob.
- flush_rob  out  rob_ndx_t  ROB index bounding the flush.
- restore_req  out  1  rename-map restore request.
- restore_cp  out  checkpt_ndx_t  checkpoint to restore.
- restore_ack  in  1  restore done; one-cycle pulse.
- redirect_v  out  1  fetch redirect valid.
- redirect_pc  out  pc_address_t  fetch redirect target.
- redirect_rdy  in  1  fetch accepts redirect.
- busy  out  1  recovery in progress; dispatch stall.
- miss_count  out  16  saturating count of accepted misses.

Function
REQ-003 FSM states SHALL be IDLE, FLUSH, RESTORE and REDIRECT; busy SHALL be 1 in every state except IDLE.
REQ-004 In IDLE, miss_flag high at a clock edge SHALL latch miss_pc, miss_rob and miss_cp, and SHALL enter FLUSH on the next cycle.
REQ-005 In FLUSH, flush SHALL be 1 for exactly FLUSH_CYCLES consecutive cycles, counted by a down-counter, with flush_rob equal to the latched ROB index; the FSM SHALL then enter RESTORE.
REQ-006 In RESTORE, restore_req SHALL be held 1 and restore_cp held stable until restore_ack is sampled high; the FSM SHALL then enter REDIRECT.
REQ-007 In REDIRECT, redirect_v SHALL be held 1 and redirect_pc held stable until redirect_rdy is sampled high; the FSM SHALL then return to IDLE, giving a 0-cycle gap before a new miss can be accepted.
REQ-008 Age of an index x SHALL be (x - rob_head) mod ROB_ENTRIES, computed in rob_ndx_t width so it wraps naturally; a smaller age is older.
REQ-009 In any non-IDLE state, miss_flag with age(miss_rob) < age(latched rob) SHALL preempt: the FSM SHALL relatch all fields, reload the flush counter and enter FLUSH next cycle.
REQ-010 In any non-IDLE state, miss_flag with age greater than or equal to the latched age SHALL be ignored and SHALL NOT change miss_count.
REQ-011 A preempting miss SHALL win over a simultaneous restore_ack or redirect_rdy; that ack or rdy SHALL be discarded.
REQ-012 miss_count SHALL increment by 1 on each accepted miss (REQ-004, REQ-009) and SHALL saturate at 16'hFFFF.
REQ-013 All outputs SHALL be registered; restore_req, redirect_v and flush SHALL be 0 in states other than their own.

Reset
REQ-014 rst low SHALL asynchronously force IDLE and drive flush, restore_req, redirect_v and busy to 0; flush_rob, restore_cp, redirect_pc and miss_count to 0; and the flush counter to 0.
REQ-015 Reset asserted mid-recovery SHALL abandon the recovery with no further request or redirect; a miss_flag arriving on the first edge after release SHALL be accepted normally.

Structure
REQ-016 pc_address_t, rob_ndx_t, checkpt_ndx_t and the recovery-state enum SHALL live in Stark_pkg.
REQ-017 The age comparison SHALL be a combinational sub-module, Stark_rob_age_cmp (inputs head, a, b; output a_older).

Verification
REQ-018 Basic: FLUSH_CYCLES=2, miss_flag with pc=0x1000, rob=5, cp=3; restore_ack 3 cycles after restore_req rises; redirect_rdy immediate -> flush high 2 cycles, restore_cp=3, redirect_pc=0x1000, busy 1 throughout, miss_count=1.
REQ-019 Preempt: rob_head=60, current rob=2, new miss rob=62 during RESTORE -> FSM restarts FLUSH with flush_rob=62, the old restore_req drops, miss_count=2.
REQ-020 Ignore: rob_head=0, current rob=10, new miss rob=20 during FLUSH -> no state change, miss_count unchanged.
REQ-021 Collision: older miss in the same cycle as restore_ack -> FLUSH re-entered, ack discarded, restore_req later reasserted for the new checkpoint.
REQ-022 Backpressure and reset: redirect_rdy held low 10 cycles -> redirect_v and redirect_pc stable; rst low in cycle 5 -> all outputs 0 immediately, IDLE after release.
REQ-023 Saturation: force 65536 accepted misses -> miss_count holds at 0xFFFF.
